// File: rtl/thread_scheduler.sv
// thread_scheduler: fine-grained multithreading thread select for the fetch stage.
// Each cycle it rotates round-robin over eligible threads (enabled and not
// stalled on memory). While an exception is outstanding, issue is locked to
// the faulting thread until the handler signals completion.
// Optional feature: define THREAD_SCHED_PERF_EN to add the perf_issue and
// perf_idle counter outputs.
module thread_scheduler #(
    parameter int unsigned N_THREADS = 8,
    parameter int unsigned THREAD_W  = $clog2(N_THREADS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_THREADS-1:0] thread_en,
    input  logic [N_THREADS-1:0] stalled,
    input  logic                 exc_en,
    input  logic [THREAD_W-1:0]  exc_thread,
    input  logic                 exc_done,
    output logic                 sched_valid,
    output logic [THREAD_W-1:0]  sched_thread,
    output logic                 exc_busy
`ifdef THREAD_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_issue,
    output logic [31:0]          perf_idle
`endif
);

    typedef enum logic {
        ST_RR  = 1'b0,
        ST_EXC = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [THREAD_W-1:0]   last_q, last_d;
    logic [THREAD_W-1:0]   exc_thread_q, exc_thread_d;
    logic                  sched_valid_q, sched_valid_d;
    logic [THREAD_W-1:0]   sched_thread_q, sched_thread_d;
    logic                  exc_busy_q, exc_busy_d;

    logic [N_THREADS-1:0]  elig;
    logic [THREAD_W-1:0]   search_base;
    logic [THREAD_W-1:0]   search_idx;
    logic [THREAD_W-1:0]   cand;
    logic                  search_found;

    assign elig = thread_en & ~stalled;

    // Rotating search: first eligible thread after the base, wrapping to itself last.
    // On exception return the search starts after the faulting thread.
    always_comb begin
        search_base  = (state_q == ST_EXC) ? exc_thread_q : last_q;
        search_found = 1'b0;
        search_idx   = search_base;
        cand         = '0;
        for (int unsigned i = 1; i <= N_THREADS; i++) begin
            cand = search_base + THREAD_W'(i);
            if (!search_found && elig[cand]) begin
                search_found = 1'b1;
                search_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic for the RR/EXC state machine.
    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        exc_thread_d   = exc_thread_q;
        sched_valid_d  = 1'b0;
        sched_thread_d = sched_thread_q;
        exc_busy_d     = 1'b0;

        case (state_q)
            ST_RR: begin
                if (exc_en) begin
                    state_d        = ST_EXC;
                    exc_thread_d   = exc_thread;
                    sched_valid_d  = elig[exc_thread];
                    sched_thread_d = exc_thread;
                    exc_busy_d     = 1'b1;
                end else if (search_found) begin
                    sched_valid_d  = 1'b1;
                    sched_thread_d = search_idx;
                    last_d         = search_idx;
                end
            end
            ST_EXC: begin
                if (exc_done) begin
                    // Return wins over a concurrent (nested) request, which is dropped.
                    state_d = ST_RR;
                    last_d  = exc_thread_q;
                    if (search_found) begin
                        sched_valid_d  = 1'b1;
                        sched_thread_d = search_idx;
                        last_d         = search_idx;
                    end
                end else begin
                    sched_valid_d  = elig[exc_thread_q];
                    sched_thread_d = exc_thread_q;
                    exc_busy_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_RR;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RR;
            last_q         <= THREAD_W'(N_THREADS - 1);
            exc_thread_q   <= '0;
            sched_valid_q  <= 1'b0;
            sched_thread_q <= '0;
            exc_busy_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            exc_thread_q   <= exc_thread_d;
            sched_valid_q  <= sched_valid_d;
            sched_thread_q <= sched_thread_d;
            exc_busy_q     <= exc_busy_d;
        end
    end

    assign sched_valid  = sched_valid_q;
    assign sched_thread = sched_thread_q;
    assign exc_busy     = exc_busy_q;

`ifdef THREAD_SCHED_PERF_EN
    logic [31:0] perf_issue_q;
    logic [31:0] perf_idle_q;

    // Issue/idle cycle counters keyed on the registered valid; wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_idle_q  <= '0;
        end else if (sched_valid_q) begin
            perf_issue_q <= perf_issue_q + 32'd1;
        end else begin
            perf_idle_q  <= perf_idle_q + 32'd1;
        end
    end

    assign perf_issue = perf_issue_q;
    assign perf_idle  = perf_idle_q;
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_thread_scheduler;

    localparam int N  = 8;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  thread_en;
    logic [N-1:0]  stalled;
    logic          exc_en;
    logic [TW-1:0] exc_thread;
    logic          exc_done;
    logic          sched_valid;
    logic [TW-1:0] sched_thread;
    logic          exc_busy;
`ifdef THREAD_SCHED_PERF_EN
    logic [31:0]   perf_issue;
    logic [31:0]   perf_idle;
`endif

    thread_scheduler #(.N_THREADS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .thread_en    (thread_en),
        .stalled      (stalled),
        .exc_en       (exc_en),
        .exc_thread   (exc_thread),
        .exc_done     (exc_done),
        .sched_valid  (sched_valid),
        .sched_thread (sched_thread),
        .exc_busy     (exc_busy)
`ifdef THREAD_SCHED_PERF_EN
        ,
        .perf_issue   (perf_issue),
        .perf_idle    (perf_idle)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Reference model state: exception lock, faulting thread, last issued.
    bit          m_exc;
    int          m_xt;
    int          m_last;
    bit          e_valid;
    int          e_thr;
    bit          e_busy;
    logic [31:0] m_issue;
    logic [31:0] m_idle;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // First eligible thread strictly after base (wrapping, base itself last); -1 if none.
    function automatic int next_elig(input int base, input logic [N-1:0] elig);
        for (int d = 1; d <= N; d++) begin
            int idx;
            idx = (base + d) % N;
            if (elig[idx]) return idx;
        end
        return -1;
    endfunction

    // Apply one cycle of inputs, advance the model across the edge.
    task automatic cycle(input logic r, input logic [N-1:0] en, input logic [N-1:0] st,
                         input logic xe, input logic [TW-1:0] xt, input logic xd);
        logic [N-1:0] el;
        bit n_exc, n_valid, n_busy;
        int n_xt, n_last, n_thr, k;
        rst = r; thread_en = en; stalled = st;
        exc_en = xe; exc_thread = xt; exc_done = xd;
        el = en & ~st;
        n_exc = m_exc; n_xt = m_xt; n_last = m_last;
        n_valid = 1'b0; n_thr = e_thr; n_busy = 1'b0;
        if (r) begin
            n_exc = 0; n_xt = 0; n_last = N - 1; n_thr = 0;
        end else if (!m_exc) begin
            if (xe) begin
                n_exc = 1; n_xt = int'(xt);
                n_valid = el[xt]; n_thr = int'(xt); n_busy = 1;
            end else begin
                k = next_elig(m_last, el);
                if (k >= 0) begin n_valid = 1; n_thr = k; n_last = k; end
            end
        end else if (xd) begin
            n_exc = 0; n_last = m_xt;
            k = next_elig(m_xt, el);
            if (k >= 0) begin n_valid = 1; n_thr = k; n_last = k; end
        end else begin
            n_valid = el[m_xt]; n_thr = m_xt; n_busy = 1;
        end
        @(posedge clk);
        if (r) begin
            m_issue = 0; m_idle = 0;
        end else if (e_valid) begin
            m_issue = m_issue + 1;
        end else begin
            m_idle = m_idle + 1;
        end
        m_exc = n_exc; m_xt = n_xt; m_last = n_last;
        e_valid = n_valid; e_thr = n_thr; e_busy = n_busy;
        #1;
    endtask

    task automatic lit(input string name, input bit v, input int t, input bit b);
        check({name, "_valid"},  32'(sched_valid),  32'(v));
        check({name, "_thread"}, 32'(sched_thread), 32'(t));
        check({name, "_busy"},   32'(exc_busy),     32'(b));
    endtask

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_valid",  32'(sched_valid),  32'(e_valid));
            check("model_thread", 32'(sched_thread), 32'(e_thr));
            check("model_busy",   32'(exc_busy),     32'(e_busy));
`ifdef THREAD_SCHED_PERF_EN
            check("model_perf_issue", perf_issue, m_issue);
            check("model_perf_idle",  perf_idle,  m_idle);
`endif
        end
    end

    initial begin
        int seq3[7];
        seq3 = '{0, 3, 4, 6, 7, 0, 3};
        m_exc = 0; m_xt = 0; m_last = N - 1;
        e_valid = 0; e_thr = 0; e_busy = 0; m_issue = 0; m_idle = 0;

        // Reset
        cycle(1, '0, '0, 0, '0, 0);
        chk_on = 1'b1;
        cycle(1, '0, '0, 0, '0, 0);
        lit("reset", 0, 0, 0);

        // All threads eligible: plain rotation with wrap
        for (int i = 0; i < 10; i++) begin
            cycle(0, 8'hFF, 8'h00, 0, '0, 0);
            lit("rr_all", 1, i % 8, 0);
        end

        // Partial stalls, full stall hold, resume
        cycle(1, 8'hFF, 8'h00, 0, '0, 0);
        for (int i = 0; i < 7; i++) begin
            cycle(0, 8'hFF, 8'b0010_0110, 0, '0, 0);
            lit("rr_stall", 1, seq3[i], 0);
        end
        cycle(0, 8'hFF, 8'hFF, 0, '0, 0);
        lit("all_stalled", 0, 3, 0);
        cycle(0, 8'hFF, 8'b0010_0110, 0, '0, 0);
        lit("resume", 1, 4, 0);

        // Exception lock on thread 5, stall inside EXC, return resumes at 6
        cycle(1, 8'hFF, 8'h00, 0, '0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 8'hFF, 8'h00, 0, '0, 0);
        lit("pre_exc", 1, 2, 0);
        cycle(0, 8'hFF, 8'h00, 1, 3'd5, 0);
        lit("exc_enter", 1, 5, 1);
        cycle(0, 8'hFF, 8'h00, 0, '0, 0);
        cycle(0, 8'hFF, 8'h00, 0, '0, 0);
        lit("exc_hold", 1, 5, 1);
        cycle(0, 8'hFF, 8'h20, 0, '0, 0);
        lit("exc_stalled", 0, 5, 1);
        cycle(0, 8'hFF, 8'h00, 0, '0, 1);
        lit("exc_return", 1, 6, 0);

        // Nested request together with return: return wins
        cycle(0, 8'hFF, 8'h00, 1, 3'd3, 0);
        lit("exc3_enter", 1, 3, 1);
        cycle(0, 8'hFF, 8'h00, 1, 3'd1, 1);
        lit("done_wins", 1, 4, 0);
        cycle(0, 8'hFF, 8'h00, 0, '0, 0);
        lit("no_lock_1", 1, 5, 0);

        // Single eligible thread, then reset during EXC
        cycle(1, 8'h01, 8'h00, 0, '0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 8'h01, 8'h00, 0, '0, 0);
            lit("single", 1, 0, 0);
        end
        cycle(0, 8'h01, 8'h00, 1, 3'd0, 0);
        lit("single_exc", 1, 0, 1);
        cycle(1, 8'h01, 8'h00, 0, '0, 0);
        lit("reset_in_exc", 0, 0, 0);

`ifdef THREAD_SCHED_PERF_EN
        // Counters: 6 valid cycles then 4 idle cycles after reset
        for (int i = 0; i < 6; i++) cycle(0, 8'hFF, 8'h00, 0, '0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 8'hFF, 8'hFF, 0, '0, 0);
        check("perf_issue_6", perf_issue, 32'd6);
        check("perf_idle_4",  perf_idle,  32'd4);
        cycle(1, 8'hFF, 8'h00, 0, '0, 0);
        check("perf_issue_rst", perf_issue, 32'd0);
        check("perf_idle_rst",  perf_idle,  32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] en, st;
            en = N'($urandom);
            st = ($urandom_range(0, 19) == 0) ? 8'hFF : N'($urandom & $urandom);
            cycle(($urandom_range(0, 149) == 0), en, st,
                  ($urandom_range(0, 9) == 0), TW'($urandom), ($urandom_range(0, 5) == 0));
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thread_scheduler.md
# thread_scheduler

Fine-grained multithreading scheduler for the in-order pipeline. Each cycle it picks the hardware thread whose PC the fetch stage uses, rotating round-robin over threads that are enabled and not stalled on memory. When an exception is raised, it locks issue to the faulting thread until the handler signals completion. It sits between the thread-state block (per-thread stall/enable bits) and stage_if, and drives the `scheduler_thread` select.

## Interface
Parameters:
- `N_THREADS`, 8: number of hardware threads; power of two, ≥2.
- `THREAD_W`, $clog2(N_THREADS): thread id width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `thread_en`  in  N_THREADS  per-thread enable mask; bit i=1 means thread i is runnable.
- `stalled`  in  N_THREADS  per-thread memory stall (d-cache/i-cache miss outstanding).
- `exc_en`  in  1  exception request pulse.
- `exc_thread`  in  THREAD_W  faulting thread, valid with `exc_en`.
- `exc_done`  in  1  handler return (iret committed) pulse.
- `sched_valid`  out  1  `sched_thread` is a legal issue this cycle.
- `sched_thread`  out  THREAD_W  selected thread.
- `exc_busy`  out  1  high while in EXC state.

## Operation
- Eligible vector: `elig = thread_en & ~stalled`.
- State machine, 2 states:
  - **RR** (reset state): issue thread `k`, the first eligible index searched from `last+1` upward, modulo N_THREADS.
    - If `elig == 0`: `sched_valid=0`, `sched_thread` holds, `last` unchanged.
    - Otherwise `last <= k`.
  - **EXC**: only `exc_thread_q` may issue. `sched_valid = elig[exc_thread_q]`, `sched_thread = exc_thread_q`. `last` is not updated.
- Transitions:
  - RR→EXC when `exc_en=1`; `exc_thread_q <= exc_thread`.
  - EXC→RR when `exc_done=1`; `last <= exc_thread_q`, so RR resumes at `exc_thread_q+1`.
- `exc_en` while in EXC: ignored (nested exceptions unsupported; the raiser must retry).
- `exc_en` and `exc_done` in the same EXC cycle: `exc_done` wins, go to RR, `exc_en` is dropped.
- `exc_done` in RR: ignored.
- Wrap-around: the search after index N_THREADS-1 continues at 0. A single eligible thread is issued every cycle.
- Reset values:
  - state=RR, `last=N_THREADS-1` (first issue is thread 0 if eligible).
  - `sched_valid=0`, `sched_thread=0`, `exc_busy=0`, `exc_thread_q=0`, perf counters 0.
- Reset mid-EXC returns to RR immediately, with no pending exception retained.

## Timing
- All outputs are registered. Inputs sampled at edge t determine the outputs visible after edge t (1-cycle latency).
- The `stalled` bit for thread i rising at edge t prevents i being selected from edge t onward. A selection already made at t-1 stands.
- `exc_en` at edge t: `exc_busy=1` and `sched_thread=exc_thread` (if eligible) after edge t.
- `exc_done` at edge t: after edge t, state is RR and the output is the first eligible thread after `exc_thread_q`.
- No combinational path from any input to any output.

## Configuration
- `THREAD_SCHED_PERF_EN` defined adds these output ports:
  - `perf_issue` (32-bit): increments on every cycle with `sched_valid=1`.
  - `perf_idle` (32-bit): increments on every cycle with `sched_valid=0`.
  - Both counters wrap at 2^32 and clear on `rst`.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

## Test plan
- Reset, then `thread_en=8'hFF`, `stalled=0` for 10 cycles → `sched_thread` sequence 0,1,…,7,0,1, `sched_valid=1` throughout.
- `thread_en=8'hFF`, `stalled=8'b0010_0110` → sequence 0,3,4,6,7,0,3. Then `stalled=8'hFF` for 1 cycle → `sched_valid=0`, `sched_thread` holds. Release → issue resumes at the next eligible thread after the last one issued.
- During RR after thread 2 issued, `exc_en=1`, `exc_thread=5` → `exc_busy=1`, `sched_thread=5` every cycle. Set `stalled[5]=1` → `sched_valid=0`. Then `exc_done` → RR resumes at 6.
- In EXC, `exc_en=1` (`exc_thread=1`) together with `exc_done=1` → state RR, `exc_busy=0`, thread 1 is not locked.
- `thread_en=8'b0000_0001` → thread 0 issued every cycle. Assert `rst` while in EXC → next cycle `exc_busy=0`, `sched_valid=0`, `sched_thread=0`.
- With `THREAD_SCHED_PERF_EN`: 6 valid cycles then 4 all-stalled cycles → `perf_issue=6`, `perf_idle=4`. `rst` clears both to 0.
